// File: rtl/hpdl_scan_writer.sv
// hpdl_scan_writer: periodically copies the 16-place character memory to four HPDL-1414
// displays, one timed setup/strobe/hold write cycle per place, with a blinking caret overlay.
module hpdl_scan_writer #(
    parameter int SETUP_CYC    = 4,
    parameter int WR_CYC       = 8,
    parameter int HOLD_CYC     = 4,
    parameter int REFRESH_DIV  = 4096,
    parameter int BLINK_FRAMES = 512
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [3:0] rd_addr,
    input  logic [6:0] rd_data,
    input  logic [3:0] caret_pos,
    input  logic       caret_en,
    output logic       busy,
    output logic       frame_done,
    output logic [6:0] HPDL_D,
    output logic [1:0] HPDL_A,
    output logic [3:0] HPDL_WR
);
    typedef enum logic [2:0] {IDLE, FETCH, SETUP, STROBE, HOLD} state_t;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    state_t        r_state, w_next;
    logic [15:0]   r_cnt, w_len;
    logic [RW-1:0] r_ref;
    logic [FW-1:0] r_fcnt;
    logic [3:0]    r_place, r_cpos;
    logic          r_pend, r_cen, r_blink, r_bl;
    logic          w_req, w_last, w_start, w_end;
    logic [6:0]    w_map, w_char;

    assign rd_addr = r_place;

    always_comb begin
        w_req   = r_ref == '0;
        w_len   = r_state == FETCH ? 16'd2 : r_state == SETUP ? 16'(SETUP_CYC) :
                  r_state == STROBE ? 16'(WR_CYC) : 16'(HOLD_CYC);
        w_last  = r_cnt == w_len - 16'd1;
        w_start = r_state == IDLE && (w_req || r_pend);
        w_end   = r_state == HOLD && w_last && r_place == 4'hF;
        w_map   = (rd_data >= 7'h61 && rd_data <= 7'h7A) ? rd_data - 7'h20 :
                  (rd_data < 7'h20 || rd_data > 7'h5F) ? 7'h20 : rd_data;
        w_char  = (r_cen && r_bl && r_place == r_cpos) ? 7'h5F : w_map;
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? FETCH : IDLE;
            FETCH:   w_next = w_last ? SETUP : FETCH;
            SETUP:   w_next = w_last ? STROBE : SETUP;
            STROBE:  w_next = w_last ? HOLD : STROBE;
            HOLD:    w_next = !w_last ? HOLD : r_place == 4'hF ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == IDLE || w_last) ? '0 : r_cnt + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ref      <= '0;
            r_pend     <= 1'b0;
            r_place    <= 4'd0;
            r_cpos     <= 4'd0;
            r_cen      <= 1'b0;
            r_bl       <= 1'b0;
            r_blink    <= 1'b0;
            r_fcnt     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            HPDL_D     <= 7'h20;
            HPDL_A     <= 2'b11;
            HPDL_WR    <= 4'hF;
        end else begin
            r_ref      <= r_ref == RW'(REFRESH_DIV - 1) ? '0 : r_ref + RW'(1);
            r_pend     <= r_state == IDLE ? 1'b0 : (r_pend | w_req);
            frame_done <= w_end;
            busy       <= w_start ? 1'b1 : w_end ? 1'b0 : busy;
            if (w_start) begin
                r_place <= 4'd0;
                r_cpos  <= caret_pos;
                r_cen   <= caret_en;
                r_bl    <= r_blink;
            end
            if (r_state == HOLD && w_last && r_place != 4'hF)
                r_place <= r_place + 4'd1;
            // D/A only move at the end of FETCH, so they are settled for the whole setup window
            if (r_state == FETCH && w_last) begin
                HPDL_D <= w_char;
                HPDL_A <= ~r_place[1:0];
            end
            HPDL_WR <= w_next == STROBE ? ~(4'b0001 << r_place[3:2]) : 4'hF;
            if (w_end) begin
                r_fcnt  <= r_fcnt == FW'(BLINK_FRAMES - 1) ? '0 : r_fcnt + FW'(1);
                r_blink <= r_blink ^ (r_fcnt == FW'(BLINK_FRAMES - 1));
            end
        end
    end
endmodule

// File: tb/tb_hpdl_scan_writer.sv
// tb_hpdl_scan_writer: directed bench; dut_a (refresh 400, blink 2) checks write content/timing,
// dut_b (refresh 200) checks back-to-back framing.
module tb_hpdl_scan_writer;
    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] caret_pos = 4'd0;
    logic       caret_en = 1'b0;
    logic [6:0] mem [16];
    logic [3:0] rda_a, rda_b, wr_a, wr_b;
    logic [6:0] rdd_a, rdd_b, d_a, d_b;
    logic [1:0] a_a, a_b;
    logic       busy_a, busy_b, fd_a, fd_b;
    int         n_cmp = 0, n_bad = 0, ncyc = 0, viol = 0, rel = 0;
    typedef struct {logic [6:0] d; logic [1:0] a; logic [3:0] wr; int len;} wr_t;
    wr_t        wq[$], cur;
    int         fdq[$], stq[$];
    logic [6:0] prev_d = 7'h20;
    logic [1:0] prev_a = 2'b11;
    logic [3:0] prev_wr = 4'hF;
    logic       prev_busy = 1'b0;
    int         stable = 0, hi_n = 100, low_n = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdd_a <= mem[rda_a];
        rdd_b <= mem[rda_b];
    end

    hpdl_scan_writer #(.REFRESH_DIV(400), .BLINK_FRAMES(2)) dut_a (
        .CLK(clk), .RST(rst), .rd_addr(rda_a), .rd_data(rdd_a), .caret_pos(caret_pos),
        .caret_en(caret_en), .busy(busy_a), .frame_done(fd_a), .HPDL_D(d_a), .HPDL_A(a_a), .HPDL_WR(wr_a));

    hpdl_scan_writer #(.REFRESH_DIV(200), .BLINK_FRAMES(2)) dut_b (
        .CLK(clk), .RST(rst), .rd_addr(rda_b), .rd_data(rdd_b), .caret_pos(caret_pos),
        .caret_en(caret_en), .busy(busy_b), .frame_done(fd_b), .HPDL_D(d_b), .HPDL_A(a_b), .HPDL_WR(wr_b));

    // Records every write window of dut_a and counts bus-discipline violations
    always @(negedge clk) begin : mon
        logic chg;
        ncyc++;
        chg = d_a !== prev_d || a_a !== prev_a;
        if (fd_a === 1'b1) fdq.push_back(ncyc);
        if (busy_a === 1'b1 && !prev_busy) stq.push_back(ncyc);
        if ($countones(~wr_a) > 1) viol++;
        if (chg && !rst && (wr_a !== 4'hF || hi_n < 4)) viol++;
        if (wr_a !== 4'hF && prev_wr === 4'hF) begin
            if (stable < 4) viol++;
            cur = '{d_a, a_a, wr_a, 0};
            low_n = 1;
        end else if (wr_a !== 4'hF) low_n++;
        if (wr_a === 4'hF && prev_wr !== 4'hF) begin
            cur.len = low_n;
            wq.push_back(cur);
        end
        hi_n = rst ? 100 : wr_a !== 4'hF ? 0 : hi_n + 1;
        stable = chg ? 1 : stable + 1;
        prev_d = d_a;
        prev_a = a_a;
        prev_wr = wr_a;
        prev_busy = busy_a === 1'b1;
    end

    task automatic release_rst();
        @(negedge clk); #1;
        rst = 1'b0;
        rel = ncyc;
        wq.delete();
        fdq.delete();
        stq.delete();
    endtask

    task automatic wait_for(input int which, input int n, input int budget);
        int k = 0;
        while ((which == 0 ? wq.size() : fdq.size()) < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if ((which == 0 ? wq.size() : fdq.size()) < n) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout %s: have %0d need %0d", which == 0 ? "writes" : "frames",
                     which == 0 ? wq.size() : fdq.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (rda_a !== 4'd0)  begin n_bad++; $display("FAIL rst_rd_addr got %h want 0", rda_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy_a); end
        n_cmp++; if (fd_a !== 1'b0)   begin n_bad++; $display("FAIL rst_frame_done got %b want 0", fd_a); end
        n_cmp++; if (d_a !== 7'h20)   begin n_bad++; $display("FAIL rst_D got %h want 20", d_a); end
        n_cmp++; if (a_a !== 2'b11)   begin n_bad++; $display("FAIL rst_A got %b want 11", a_a); end
        n_cmp++; if (wr_a !== 4'hF)   begin n_bad++; $display("FAIL rst_WR got %b want 1111", wr_a); end
        n_cmp++; if (wr_b !== 4'hF || busy_b !== 1'b0) begin n_bad++; $display("FAIL rst_b got wr=%b busy=%b want 1111/0", wr_b, busy_b); end
    endtask

    task automatic test_first_frame();
        int s;
        foreach (mem[i]) mem[i] = 7'h20;
        mem[0] = 7'h48; mem[1] = 7'h45; mem[2] = 7'h4C; mem[3] = 7'h4C; mem[4] = 7'h4F;
        caret_en = 1'b0;
        release_rst();
        wait_for(1, 1, 400);
        s = stq.size() > 0 ? stq[0] : -1;
        n_cmp++; if (s !== rel + 1) begin n_bad++; $display("FAIL start_latency got %0d want %0d", s, rel + 1); end
        s = (stq.size() > 0 && fdq.size() > 0) ? fdq[0] - stq[0] : -1;
        n_cmp++; if (s !== 288) begin n_bad++; $display("FAIL frame_len got %0d want 288", s); end
        n_cmp++; if (wq.size() !== 16) begin n_bad++; $display("FAIL write_count got %0d want 16", wq.size()); end
        n_cmp++; if (wq[0].d !== 7'h48 || wq[0].a !== 2'b11 || wq[0].wr !== 4'b1110)
            begin n_bad++; $display("FAIL place0 got d=%h a=%b wr=%b want 48/11/1110", wq[0].d, wq[0].a, wq[0].wr); end
        n_cmp++; if (wq[0].len !== 8) begin n_bad++; $display("FAIL place0_wr_len got %0d want 8", wq[0].len); end
        n_cmp++; if (wq[4].d !== 7'h4F || wq[4].a !== 2'b11 || wq[4].wr !== 4'b1101)
            begin n_bad++; $display("FAIL place4 got d=%h a=%b wr=%b want 4f/11/1101", wq[4].d, wq[4].a, wq[4].wr); end
        n_cmp++; if (wq[15].d !== 7'h20 || wq[15].a !== 2'b00 || wq[15].wr !== 4'b0111)
            begin n_bad++; $display("FAIL place15 got d=%h a=%b wr=%b want 20/00/0111", wq[15].d, wq[15].a, wq[15].wr); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL bus_discipline got %0d violations want 0", viol); end
    endtask

    task automatic test_mapping();
        mem[5] = 7'h61; mem[6] = 7'h0A; mem[7] = 7'h7E; mem[8] = 7'h7A;
        mem[10] = 7'h5F; mem[11] = 7'h1F; mem[12] = 7'h60;
        wq.delete();
        wait_for(1, 2, 500);
        n_cmp++; if (wq[5].d !== 7'h41)  begin n_bad++; $display("FAIL map_61 got %h want 41", wq[5].d); end
        n_cmp++; if (wq[6].d !== 7'h20)  begin n_bad++; $display("FAIL map_0a got %h want 20", wq[6].d); end
        n_cmp++; if (wq[7].d !== 7'h20)  begin n_bad++; $display("FAIL map_7e got %h want 20", wq[7].d); end
        n_cmp++; if (wq[8].d !== 7'h5A)  begin n_bad++; $display("FAIL map_7a got %h want 5a", wq[8].d); end
        n_cmp++; if (wq[10].d !== 7'h5F) begin n_bad++; $display("FAIL map_5f got %h want 5f", wq[10].d); end
        n_cmp++; if (wq[11].d !== 7'h20) begin n_bad++; $display("FAIL map_1f got %h want 20", wq[11].d); end
        n_cmp++; if (wq[12].d !== 7'h20) begin n_bad++; $display("FAIL map_60 got %h want 20", wq[12].d); end
        n_cmp++; if (wq[6].a !== 2'b01 || wq[6].wr !== 4'b1101)
            begin n_bad++; $display("FAIL place6_addr got a=%b wr=%b want 01/1101", wq[6].a, wq[6].wr); end
    endtask

    task automatic test_back_to_back();
        int st = -1, low = 0, maxlow = 0, fds[$];
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();
        for (int k = 0; k < 1600; k++) begin
            @(negedge clk); #1;
            if (busy_b === 1'b1 && st < 0) st = k;
            if (fd_b === 1'b1) fds.push_back(k);
            low = (st >= 0 && busy_b !== 1'b1) ? low + 1 : 0;
            if (low > maxlow) maxlow = low;
        end
        n_cmp++; if (fds.size() < 5) begin n_bad++; $display("FAIL b2b_frames got %0d want >=5", fds.size()); end
        n_cmp++; if (fds.size() == 0 || fds[0] - st !== 288)
            begin n_bad++; $display("FAIL b2b_first got %0d want 288", fds.size() ? fds[0] - st : -1); end
        for (int i = 1; i < 5 && i < fds.size(); i++) begin
            n_cmp++; if (fds[i] - fds[i-1] !== 289)
                begin n_bad++; $display("FAIL b2b_period%0d got %0d want 289", i, fds[i] - fds[i-1]); end
        end
        n_cmp++; if (maxlow > 1) begin n_bad++; $display("FAIL b2b_busy_gap got %0d want <=1", maxlow); end
    endtask

    task automatic test_blink();
        logic [6:0] exp [6] = '{7'h41, 7'h41, 7'h5F, 7'h5F, 7'h41, 7'h41};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mem[9] = 7'h41;
        caret_pos = 4'd9;
        caret_en = 1'b1;
        release_rst();
        wait_for(1, 6, 2600);
        for (int f = 0; f < 6; f++) begin
            n_cmp++; if (wq[16*f+9].d !== exp[f])
                begin n_bad++; $display("FAIL blink_frame%0d got %h want %h", f, wq[16*f+9].d, exp[f]); end
        end
        n_cmp++; if (wq[16*2+8].d !== 7'h5A) begin n_bad++; $display("FAIL blink_other_place got %h want 5a", wq[40].d); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL bus_discipline2 got %0d want 0", viol); end
    endtask

    task automatic test_caret_change();
        wait_for(0, 16*6 + 5, 500);
        caret_pos = 4'd2;
        wait_for(1, 8, 900);
        n_cmp++; if (wq[96+9].d !== 7'h5F)  begin n_bad++; $display("FAIL caret_cur9 got %h want 5f", wq[105].d); end
        n_cmp++; if (wq[96+2].d !== 7'h4C)  begin n_bad++; $display("FAIL caret_cur2 got %h want 4c", wq[98].d); end
        n_cmp++; if (wq[112+2].d !== 7'h5F) begin n_bad++; $display("FAIL caret_next2 got %h want 5f", wq[114].d); end
        n_cmp++; if (wq[112+9].d !== 7'h41) begin n_bad++; $display("FAIL caret_next9 got %h want 41", wq[121].d); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        rst = 1'b1;
        caret_en = 1'b0;
        repeat (2) @(negedge clk);
        release_rst();
        wait_for(0, 4, 300);
        while (wr_a !== 4'b1101 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (wr_a !== 4'b1101) begin n_bad++; $display("FAIL mid_strobe got %b want 1101", wr_a); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (wr_a !== 4'hF)  begin n_bad++; $display("FAIL mid_rst_WR got %b want 1111", wr_a); end
        n_cmp++; if (d_a !== 7'h20 || a_a !== 2'b11) begin n_bad++; $display("FAIL mid_rst_DA got %h/%b want 20/11", d_a, a_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy_a); end
        n_cmp++; if (wr_b !== 4'hF || busy_b !== 1'b0) begin n_bad++; $display("FAIL mid_rst_b got %b/%b want 1111/0", wr_b, busy_b); end
        release_rst();
        @(negedge clk); #1;
        n_cmp++; if (busy_a !== 1'b1 || rda_a !== 4'd0) begin n_bad++; $display("FAIL restart got busy=%b addr=%h want 1/0", busy_a, rda_a); end
        wait_for(0, 1, 40);
        n_cmp++; if (wq[0].d !== 7'h48 || wq[0].a !== 2'b11 || wq[0].wr !== 4'b1110 || wq[0].len !== 8)
            begin n_bad++; $display("FAIL restart_place0 got d=%h a=%b wr=%b len=%0d want 48/11/1110/8", wq[0].d, wq[0].a, wq[0].wr, wq[0].len); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 7'h20;
        test_reset();
        test_first_frame();
        test_mapping();
        test_back_to_back();
        test_blink();
        test_caret_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
